// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU control path: opcodes, sequencer states, ALU ops.
package cpu_pkg;

    localparam int DEF_ADDR_W = 5;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDA = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_STA = 3'b100,
        OP_JMP = 3'b101,
        OP_JZ  = 3'b110,
        OP_HLT = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM    = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10
    } alu_op_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Sequencer-side bundle: instruction/data memory handshakes, PC control and datapath strobes.
interface ctrl_sequencer_if #(
    parameter int ADDR_W  = cpu_pkg::DEF_ADDR_W,
    parameter int INSTR_W = ADDR_W + 3
);
    logic [INSTR_W-1:0] instr;
    logic               imem_ready;
    logic               dmem_ready;
    logic               acc_zero;
    logic               imem_req;
    logic               dmem_req;
    logic               dmem_we;
    logic [ADDR_W-1:0]  dmem_addr;
    logic               pc_en;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc_target;
    logic               acc_load;
    logic [1:0]         alu_op;
    logic               halted;

    modport master (
        input  instr, imem_ready, dmem_ready, acc_zero,
        output imem_req, dmem_req, dmem_we, dmem_addr, pc_en, pc_load,
               pc_target, acc_load, alu_op, halted
    );

    modport slave (
        output instr, imem_ready, dmem_ready, acc_zero,
        input  imem_req, dmem_req, dmem_we, dmem_addr, pc_en, pc_load,
               pc_target, acc_load, alu_op, halted
    );
endinterface

// File: rtl/ctrl_sequencer_decoder.sv
// Opcode classifier: class flags steering the sequencer FSM plus the ALU operation.
module instr_decoder
    import cpu_pkg::*;
(
    input  opcode_t opcode_i,
    output logic    is_mem_o,
    output logic    is_store_o,
    output logic    is_jump_o,
    output logic    is_cond_o,
    output logic    is_halt_o,
    output alu_op_t alu_op_o
);
    always_comb begin
        is_mem_o   = 1'b0;
        is_store_o = 1'b0;
        is_jump_o  = 1'b0;
        is_cond_o  = 1'b0;
        is_halt_o  = 1'b0;
        alu_op_o   = ALU_PASS;
        case (opcode_i)
            OP_LDA: is_mem_o = 1'b1;
            OP_ADD: begin
                is_mem_o = 1'b1;
                alu_op_o = ALU_ADD;
            end
            OP_SUB: begin
                is_mem_o = 1'b1;
                alu_op_o = ALU_SUB;
            end
            OP_STA: begin
                is_mem_o   = 1'b1;
                is_store_o = 1'b1;
            end
            OP_JMP: is_jump_o = 1'b1;
            OP_JZ: begin
                is_jump_o = 1'b1;
                is_cond_o = 1'b1;
            end
            OP_HLT: is_halt_o = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute sequencer: owns the state and IR registers, drives PC, memories and ACC strobes.
module ctrl_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = ADDR_W + 3
) (
    input  logic              clk,
    input  logic              rst,
    ctrl_sequencer_if.master  bus
);
    seq_state_t         state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;

    logic    dec_mem, dec_store, dec_jump, dec_cond, dec_halt;
    alu_op_t dec_alu;

    instr_decoder u_dec (
        .opcode_i   (opcode_t'(ir_q[INSTR_W-1:ADDR_W])),
        .is_mem_o   (dec_mem),
        .is_store_o (dec_store),
        .is_jump_o  (dec_jump),
        .is_cond_o  (dec_cond),
        .is_halt_o  (dec_halt),
        .alu_op_o   (dec_alu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    ir_d    = bus.instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_halt)     state_d = ST_HALT;
                else if (dec_mem) state_d = ST_MEM;
                else              state_d = ST_FETCH;
            end
            ST_MEM: begin
                if (bus.dmem_ready) state_d = dec_store ? ST_FETCH : ST_EXEC;
            end
            ST_EXEC: state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Operand and ALU op are always visible; consumers qualify them with the strobes.
    always_comb begin
        bus.imem_req  = 1'b0;
        bus.dmem_req  = 1'b0;
        bus.dmem_we   = 1'b0;
        bus.pc_en     = 1'b0;
        bus.pc_load   = 1'b0;
        bus.acc_load  = 1'b0;
        bus.halted    = 1'b0;
        bus.dmem_addr = ir_q[ADDR_W-1:0];
        bus.pc_target = ir_q[ADDR_W-1:0];
        bus.alu_op    = dec_alu;
        case (state_q)
            ST_FETCH: begin
                bus.imem_req = 1'b1;
                bus.pc_en    = bus.imem_ready;
            end
            ST_DECODE: begin
                if (dec_jump && (!dec_cond || bus.acc_zero)) begin
                    bus.pc_en   = 1'b1;
                    bus.pc_load = 1'b1;
                end
            end
            ST_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = dec_store;
            end
            ST_EXEC: bus.acc_load = 1'b1;
            ST_HALT: bus.halted   = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: walks each opcode class, memory waits, halt and mid-op reset.
module tb_ctrl_sequencer;
    localparam logic [6:0] IMEM = 7'h40;
    localparam logic [6:0] DMEM = 7'h20;
    localparam logic [6:0] WE   = 7'h10;
    localparam logic [6:0] PCEN = 7'h08;
    localparam logic [6:0] PCLD = 7'h04;
    localparam logic [6:0] ACC  = 7'h02;
    localparam logic [6:0] HALT = 7'h01;

    logic clk;
    logic rst;
    int   nchk;
    int   npass;

    ctrl_sequencer_if #(.ADDR_W(5), .INSTR_W(8)) bus ();

    ctrl_sequencer #(.ADDR_W(5), .INSTR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] stb;
    assign stb = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.pc_en,
                  bus.pc_load, bus.acc_load, bus.halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] ins, input string tag);
        bus.instr      = ins;
        bus.imem_ready = 1'b1;
        #1;
        chk({tag, "_fetch"}, 32'(stb), 32'(IMEM | PCEN));
        tick();
        bus.imem_ready = 1'b0;
        bus.instr      = 8'h00;
    endtask

    // Zero-wait load/arith instruction: fetch, decode, one MEM cycle, EXEC.
    task automatic do_alu(input logic [7:0] ins, input logic [1:0] op, input string tag);
        fetch(ins, tag);
        #1;
        chk({tag, "_decode"}, 32'(stb), 32'(0));
        tick();
        bus.dmem_ready = 1'b1;
        #1;
        chk({tag, "_mem"}, 32'(stb), 32'(DMEM));
        chk({tag, "_addr"}, 32'(bus.dmem_addr), 32'(ins[4:0]));
        tick();
        bus.dmem_ready = 1'b0;
        #1;
        chk({tag, "_exec"}, 32'(stb), 32'(ACC));
        chk({tag, "_aluop"}, 32'(bus.alu_op), 32'(op));
        tick();
        #1;
        chk({tag, "_refetch"}, 32'(stb), 32'(IMEM));
    endtask

    initial begin
        nchk = 0;
        npass = 0;
        rst = 1'b1;
        bus.instr = 8'h00;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.acc_zero = 1'b0;

        // reset for 2 cycles
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_stb", 32'(stb), 32'(IMEM));
        chk("rst_addr", 32'(bus.dmem_addr), 32'(0));
        chk("rst_target", 32'(bus.pc_target), 32'(0));
        chk("rst_aluop", 32'(bus.alu_op), 32'(0));
        tick();
        #1;
        chk("fetch_hold", 32'(stb), 32'(IMEM));

        // NOP
        fetch(8'h00, "nop");
        #1;
        chk("nop_decode", 32'(stb), 32'(0));
        tick();
        #1;
        chk("nop_back", 32'(stb), 32'(IMEM));

        // LDA 5 with 3 wait cycles: 7 cycles total
        fetch(8'h25, "lda");
        #1;
        chk("lda_decode", 32'(stb), 32'(0));
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.dmem_ready = (i == 3);
            #1;
            chk("lda_mem", 32'(stb), 32'(DMEM));
            chk("lda_addr", 32'(bus.dmem_addr), 32'(5));
            tick();
        end
        bus.dmem_ready = 1'b0;
        #1;
        chk("lda_exec", 32'(stb), 32'(ACC));
        chk("lda_aluop", 32'(bus.alu_op), 32'(0));
        tick();
        #1;
        chk("lda_done", 32'(stb), 32'(IMEM));

        do_alu(8'h43, 2'b01, "add");
        do_alu(8'h6A, 2'b10, "sub");

        // STA 31
        fetch(8'h9F, "sta");
        #1;
        chk("sta_decode", 32'(stb), 32'(0));
        tick();
        bus.dmem_ready = 1'b1;
        #1;
        chk("sta_mem", 32'(stb), 32'(DMEM | WE));
        chk("sta_addr", 32'(bus.dmem_addr), 32'(31));
        tick();
        bus.dmem_ready = 1'b0;
        #1;
        chk("sta_next", 32'(stb), 32'(IMEM));

        // JZ 3 taken
        bus.acc_zero = 1'b1;
        fetch(8'hC3, "jz_t");
        #1;
        chk("jz_t_decode", 32'(stb), 32'(PCEN | PCLD));
        chk("jz_t_target", 32'(bus.pc_target), 32'(3));
        tick();
        bus.acc_zero = 1'b0;
        #1;
        chk("jz_t_next", 32'(stb), 32'(IMEM));

        // JZ 3 not taken
        fetch(8'hC3, "jz_n");
        #1;
        chk("jz_n_decode", 32'(stb), 32'(0));
        tick();
        #1;
        chk("jz_n_next", 32'(stb), 32'(IMEM));

        // JMP 16 with acc_zero low
        fetch(8'hB0, "jmp");
        #1;
        chk("jmp_decode", 32'(stb), 32'(PCEN | PCLD));
        chk("jmp_target", 32'(bus.pc_target), 32'(16));
        tick();
        #1;
        chk("jmp_next", 32'(stb), 32'(IMEM));

        // HLT: readies toggling must not wake it
        fetch(8'hE0, "hlt");
        #1;
        chk("hlt_decode", 32'(stb), 32'(0));
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.imem_ready = i[0];
            bus.dmem_ready = ~i[0];
            bus.acc_zero   = 1'b1;
            #1;
            chk("hlt_stay", 32'(stb), 32'(HALT));
            tick();
        end
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.acc_zero   = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("hlt_rst", 32'(stb), 32'(IMEM));

        // reset while ADD waits in MEM
        fetch(8'h42, "addr");
        tick();
        #1;
        chk("addr_mem", 32'(stb), 32'(DMEM));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("addr_drop", 32'(stb), 32'(IMEM));
        tick();
        #1;
        chk("addr_noacc", 32'(stb), 32'(IMEM));

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Fetch/decode/execute control sequencer for the 5-bit-address accumulator CPU. It drives the program counter's `en`/`load`/`data_in` inputs and the instruction/data memory request handshakes, and consumes the instruction word and the accumulator-zero flag. It sits between the program counter, the memories and the accumulator/ALU datapath, and it is the only block that advances or redirects the PC.

## Interface
- `ADDR_W`, default 5: address width; it matches the PC width.
- `INSTR_W`, default `ADDR_W+3`: instruction width, laid out as opcode[INSTR_W-1:ADDR_W] and operand[ADDR_W-1:0].
- `clk`  in  1: the single clock. All state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `instr`  in  INSTR_W: instruction memory read data. Valid only when `imem_ready` is high.
- `imem_ready`  in  1: instruction fetch completes in this cycle.
- `dmem_ready`  in  1: data access completes in this cycle.
- `acc_zero`  in  1: the accumulator equals 0.
- `imem_req`  out  1: instruction fetch request.
- `dmem_req`  out  1: data memory request.
- `dmem_we`  out  1: data memory write (used by STA).
- `dmem_addr`  out  ADDR_W: data address, equal to IR operand.
- `pc_en`  out  1: PC enable.
- `pc_load`  out  1: PC load select. 1 means load `pc_target`; 0 means increment.
- `pc_target`  out  ADDR_W: jump target, equal to IR operand.
- `acc_load`  out  1: accumulator write strobe.
- `alu_op`  out  2: ALU operation. 00 = pass, 01 = add, 10 = sub.
- `halted`  out  1: the core is stopped.

## Operation
- **Opcodes:**
  - 000 NOP
  - 001 LDA a
  - 010 ADD a
  - 011 SUB a
  - 100 STA a
  - 101 JMP a
  - 110 JZ a
  - 111 HLT
- **States:** FETCH, DECODE, MEM, EXEC, HALT.
- **FETCH:**
  - `imem_req`=1.
  - On `imem_ready`=1: IR <= `instr`, `pc_en`=1 with `pc_load`=0 (increment) in that same cycle, next state DECODE.
  - Otherwise stay in FETCH with the request held.
- **DECODE:**
  - NOP → FETCH.
  - LDA/ADD/SUB/STA → MEM.
  - JMP → `pc_en`=1, `pc_load`=1, then FETCH.
  - JZ → if `acc_zero`=1, same as JMP; otherwise FETCH with `pc_en`=0.
  - HLT → HALT.
- **MEM:**
  - `dmem_req`=1 and `dmem_addr`=operand.
  - `dmem_we`=1 only for STA.
  - On `dmem_ready`=1: STA → FETCH; all others → EXEC.
  - Otherwise hold every output unchanged.
- **EXEC:** `acc_load`=1 for one cycle, with `alu_op` = 00 for LDA, 01 for ADD, 10 for SUB. Next state FETCH.
- **HALT:** `halted`=1 and all other strobes 0. Only `rst` leaves this state.
- **Output derivation:**
  - All outputs are combinational from the state and IR registers.
  - `pc_en` in FETCH is additionally gated by `imem_ready`.
  - `alu_op`, `pc_target` and `dmem_addr` show IR-derived values in every state. They are qualified by their strobes.
- `pc_en` pulses exactly once per fetched instruction, plus once more for a taken jump. The sequencer never issues two PC updates in the same cycle.
- `imem_ready` outside FETCH and `dmem_ready` outside MEM are ignored.
- PC wrap-around (31→0) is the PC's responsibility. The sequencer is unaffected by it.

## Timing
- **Reset values:**
  - state = FETCH and IR = 0.
  - `imem_req`=1 (the FETCH decode) on the first cycle after reset.
  - Every other output is 0.
- **Reset mid-operation:** `rst` sampled high in any state forces FETCH at that edge. A pending `dmem_req` or `acc_load` is dropped immediately, with no completion.
- **Handshake:**
  - A request stays high until the matching ready is sampled high.
  - A ready in the first request cycle completes the transfer in that cycle. This is zero wait.
- **Latency with zero-wait memories:**
  - NOP, JMP, JZ: 2 cycles.
  - STA: 3 cycles.
  - LDA, ADD, SUB: 4 cycles.
  - Each memory wait cycle adds 1.
- `acc_zero` is sampled only in the DECODE cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - the `opcode_t` enum (3-bit);
  - the `seq_state_t` enum;
  - the `alu_op_t` enum;
  - the `ADDR_W` default constant.
- One combinational sub-module, `instr_decoder`. It maps the opcode to class flags (is_mem, is_store, is_jump, is_cond, is_halt) and to `alu_op`.
- The top module holds the state register, the IR register and the output decode.

## Test plan
- **Reset, then fetch NOP:**
  - Stimulus: `rst` for 2 cycles, then `imem_ready`=1 with `instr`=0x00.
  - Required: `imem_req`=1 after reset; `pc_en`=1 with `pc_load`=0 for exactly 1 cycle; back in FETCH 2 cycles later.
- **LDA 0x05 with `dmem_ready` delayed 3 cycles:**
  - Required: `dmem_req`=1 and `dmem_addr`=5 held 4 cycles, with `dmem_we`=0.
  - Then one cycle of `acc_load`=1 with `alu_op`=00.
  - Instruction total is 7 cycles.
- **STA 0x1F (instr 0x9F):**
  - Required: `dmem_we`=1 and `dmem_addr`=31 while `dmem_req` is high.
  - No `acc_load`; next state FETCH.
- **JZ 0x03:**
  - With `acc_zero`=1: `pc_en`=1, `pc_load`=1 and `pc_target`=3 in the DECODE cycle.
  - With `acc_zero`=0: no extra `pc_en`.
  - JMP 0x10: target 16 unconditionally.
- **HLT (instr 0xE0):**
  - Required: `halted`=1 from the next cycle onward.
  - `imem_ready` and `dmem_ready` toggling must produce no strobes.
  - `rst` then returns the block to FETCH with `halted`=0.
- **Reset in MEM during an ADD wait:**
  - Required: `dmem_req` drops at that edge and no `acc_load` occurs.
  - Fetching resumes with `imem_req`=1.
